// File: rtl/fib_seq.sv
`default_nettype none
// ============================================================================
//  Module   : fib_seq
//  Purpose  : Fibonacci engine. Accepts an index n on a one-cycle `read`
//             strobe (while `ready`) and returns either F(n) alone
//             (mode=0) or the whole sequence F(0)..F(n) (mode=1), one term
//             per write/ack handshake. `ovf` flags, per job, that an emitted
//             term needed more than WIDTH bits.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             read, a, mode   - start strobe, index n, output mode
//             ready           - engine idle, `read` will be accepted
//             b, write, last  - current term, term valid, final term
//             ack             - consumer accepts `b` on an edge with write=1
//             ovf             - sticky per-job overflow flag
//  Options  : FIB_SAT_EN      - defined: overflowed terms clamp to 2^WIDTH-1
//                               undefined: terms wrap modulo 2^WIDTH
//  Revision : 1.0 - initial release
// ============================================================================
module fib_seq #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             read,
    input  logic [IDX_W-1:0] a,
    input  logic             mode,
    output logic             ready,
    output logic [WIDTH-1:0] b,
    output logic             write,
    input  logic             ack,
    output logic             last,
    output logic             ovf
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_PREP = 3'd1;  // one settling cycle after accept
    localparam logic [2:0] c_CALC = 3'd2;  // nth mode: step until rem==0
    localparam logic [2:0] c_LOAD = 3'd3;  // stream mode: present F(0)
    localparam logic [2:0] c_EMIT = 3'd4;  // hold term until ack

    logic [2:0]       r_state;
    logic [2:0]       w_next;

    logic [WIDTH-1:0] r_x;       // F(k)
    logic [WIDTH-1:0] r_y;       // F(k+1)
    logic [IDX_W-1:0] r_rem;     // steps / terms still to go
    logic             r_mode;
    logic             r_yc;      // r_y holds a term that exceeded WIDTH bits
    logic [WIDTH-1:0] r_b;
    logic             r_write;
    logic             r_last;
    logic             r_ovf;

    logic [WIDTH:0]   w_sum;
    logic             w_carry;
    logic [WIDTH-1:0] w_ynext;

    assign w_sum   = {1'b0, r_x} + {1'b0, r_y};
    assign w_carry = w_sum[WIDTH];

`ifdef FIB_SAT_EN
    // Once y clamps, every later sum carries again, so the clamp persists.
    assign w_ynext = w_carry ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
`else
    assign w_ynext = w_sum[WIDTH-1:0];
`endif

    assign ready = (r_state == c_IDLE);
    assign b     = r_b;
    assign write = r_write;
    assign last  = r_last;
    assign ovf   = r_ovf;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: if (read) w_next = c_PREP;
            c_PREP: w_next = r_mode ? c_LOAD : c_CALC;
            c_CALC: if (r_rem == '0) w_next = c_EMIT;
            c_LOAD: w_next = c_EMIT;
            c_EMIT: if (ack && r_last) w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath. A "step" moves (x,y) from (F(k),F(k+1)) to
    // (F(k+1),F(k+2)). The carry of the new y is parked in r_yc and only
    // folded into ovf when that term moves into x / b, so a look-ahead
    // term beyond F(n) never raises ovf.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x     <= '0;
            r_y     <= '0;
            r_rem   <= '0;
            r_mode  <= 1'b0;
            r_yc    <= 1'b0;
            r_b     <= '0;
            r_write <= 1'b0;
            r_last  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (read) begin
                        r_x    <= '0;
                        r_y    <= {{(WIDTH-1){1'b0}}, 1'b1};
                        r_rem  <= a;
                        r_mode <= mode;
                        r_ovf  <= 1'b0;
                        r_yc   <= 1'b0;
                    end
                end
                c_CALC: begin
                    if (r_rem == '0) begin
                        r_b     <= r_x;
                        r_last  <= 1'b1;
                        r_write <= 1'b1;
                    end else begin
                        r_x   <= r_y;
                        r_y   <= w_ynext;
                        r_yc  <= r_yc | w_carry;
                        r_ovf <= r_ovf | r_yc;
                        r_rem <= r_rem - IDX_W'(1);
                    end
                end
                c_LOAD: begin
                    r_b     <= r_x;
                    r_write <= 1'b1;
                    r_last  <= (r_rem == '0);
                end
                c_EMIT: begin
                    if (ack) begin
                        if (r_last) begin
                            r_write <= 1'b0;
                            r_last  <= 1'b0;
                        end else if (r_mode) begin
                            r_b    <= r_y;
                            r_x    <= r_y;
                            r_y    <= w_ynext;
                            r_yc   <= r_yc | w_carry;
                            r_ovf  <= r_ovf | r_yc;
                            r_rem  <= r_rem - IDX_W'(1);
                            r_last <= (r_rem == IDX_W'(1));
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/fib_seq.md
# fib_seq

Parametrised Fibonacci engine that succeeds the fixed-width `read`/`write` Fibonacci block used in the generated-primitive test flow. It accepts an index `n` on a one-cycle `read` strobe and returns either F(n) alone or the whole sequence F(0)..F(n), one term per handshake. The output uses a `write`/`ack` back-pressure handshake and reports overflow per job. It sits behind `primitives.v` and plugs into the same testbench harness as the other generated arithmetic blocks.

## Interface
- `WIDTH`, 16, data width of result `b`; matches `` `intN `` by default; unsigned.
- `IDX_W`, 8, width of index input `a`.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `read`  in  1  start strobe; sampled only when `ready`=1.
- `a`  in  IDX_W  index n, unsigned; captured on accepted `read`.
- `mode`  in  1  0 = nth (emit F(n) only), 1 = stream (emit F(0)..F(n)); captured with `a`.
- `ready`  out  1  high in IDLE.
- `b`  out  WIDTH  current term.
- `write`  out  1  term valid; held until `ack`.
- `ack`  in  1  consumer accepts `b` on a rising edge where `write`=1.
- `last`  out  1  qualifies `b` as the final term of the job.
- `ovf`  out  1  sticky per job; set when any computed term needs more than WIDTH bits.

## Operation
- F(0)=0, F(1)=1, F(k+1)=F(k)+F(k-1).
- Registers: `x`=F(k), `y`=F(k+1), down-counter `rem` (IDX_W), captured `mode_q`.
- States:
  - IDLE: `ready`=1. On `read`: `x`<=0, `y`<=1, `rem`<=`a`, `mode_q`<=`mode`, `ovf`<=0; go to CALC (nth) or EMIT-prep (stream).
  - CALC (nth): if `rem`==0, `b`<=`x`, `last`<=1, `write`<=1, go to EMIT. Otherwise `x`<=`y`, `y`<=`x`+`y`, `rem`<=`rem`-1.
  - STREAM-LOAD: `b`<=`x`, `write`<=1, `last`<=(`rem`==0), go to EMIT.
  - EMIT: hold `b`/`last`/`write` stable while `ack`=0.
    - On `ack` with `last`=1: `write`<=0, `last`<=0, go to IDLE.
    - On `ack` in stream mode with `last`=0: advance one step, and in the same edge `b`<=`y` (the next term), `rem`<=`rem`-1, `last`<=(`rem`==1); `write` stays 1.
- Addition is performed at WIDTH+1 bits. A carry-out sets `ovf`; the term value is governed by Configuration.
- `read` outside IDLE is ignored, with no queueing. `ack` while `write`=0 is ignored.
- `rst` at any edge forces IDLE regardless of state and discards any job in progress.
- Reset values: `ready`=1 (combinational from IDLE), `b`=0, `write`=0, `last`=0, `ovf`=0, internal registers 0.

## Timing
- Edge E0 accepts `read`. The first `write`=1 appears after:
  - nth mode: edge E(n+2), so n=0 gives `write` after E2.
  - stream mode: edge E2.
- Stream throughput: with `ack` held high, one new term per clock. Term k is visible after edge E(2+k).
- Back-pressure: every cycle with `ack`=0 adds exactly one cycle. Outputs stay unchanged during the stall.
- Final `ack` edge: `write` and `last` are low and `ready` is high after that same edge. A `read` on the next edge is accepted, so there is no dead cycle.
- `ovf` is valid whenever `write`=1. It holds until the next accepted `read` or `rst`.

## Configuration
- `FIB_SAT_EN` defined:
  - On overflow, the term and all later terms clamp to 2^WIDTH-1.
  - `y` is clamped as well.
  - `ovf`=1.
- `FIB_SAT_EN` undefined:
  - Arithmetic wraps modulo 2^WIDTH.
  - `ovf` still flags the carry-out.

## Test plan
- Nth, n=21, WIDTH=16, `ack`=1 after E0 → `write` after E23, `b`=10946, `last`=1, `ovf`=0. `ready` returns after the next edge.
- Nth, n=0 and n=1 → `b`=0 then `b`=1 on separate jobs, both `last`=1. The second `read` is issued on the cycle after the first final `ack` and is accepted.
- Nth, n=25, WIDTH=16 → with `FIB_SAT_EN`: `b`=65535, `ovf`=1. Without it: `b`=9489, `ovf`=1. Also n=24 → `b`=46368, `ovf`=0.
- Stream, n=5, `ack` held high → `b`=0,1,1,2,3,5 on consecutive cycles. `last`=1 only with 5; `write` drops after the following edge.
- Stream, n=5, `ack` low for 3 cycles while `b`=2 → `b`, `write`, `last` remain unchanged. A `read` pulse asserted mid-job is ignored; `a` changes do not disturb the job.
- `rst` asserted for one cycle during CALC of n=21 → after that edge `write`=0, `b`=0, `ovf`=0, `ready`=1. A fresh n=10 job then yields 55.
